// File: rtl/apb_demux_wd_if.sv
// Bus bundle for apb_demux_wd: the upstream master port plus the fan-out of N
// slave ports. Signal names are given from the demultiplexer's point of view.
interface apb_demux_wd_if #(
  parameter int unsigned APB_SLAVE_COUNT = 8,
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned APB_DATA_WIDTH  = 32
);
  // Upstream master side
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [APB_DATA_WIDTH-1:0] pwdata_i;
  logic [APB_DATA_WIDTH-1:0] prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  // Downstream slave side, one lane per slave
  logic [APB_SLAVE_COUNT-1:0]                     psel_o;
  logic [APB_SLAVE_COUNT-1:0]                     penable_o;
  logic [APB_SLAVE_COUNT-1:0]                     pwrite_o;
  logic [APB_SLAVE_COUNT-1:0][APB_ADDR_WIDTH-1:0] paddr_o;
  logic [APB_SLAVE_COUNT-1:0][APB_DATA_WIDTH-1:0] pwdata_o;
  logic [APB_SLAVE_COUNT-1:0][APB_DATA_WIDTH-1:0] prdata_i;
  logic [APB_SLAVE_COUNT-1:0]                     pready_i;
  logic [APB_SLAVE_COUNT-1:0]                     pslverr_i;

  // The demultiplexer itself
  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output prdata_o, pready_o, pslverr_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  // Everything around it: the upstream master and the downstream slaves
  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  prdata_o, pready_o, pslverr_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_demux_wd.sv
// Registered APB 1-to-N demultiplexer with window decode, a one-cycle decode-error
// response and a watchdog that force-completes a hung slave access.
module apb_demux_wd #(
  parameter int unsigned APB_SLAVE_COUNT = 8,
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned APB_DATA_WIDTH  = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR [APB_SLAVE_COUNT] = '{
    'h0000_0000, 'h1000_0000, 'h2000_0000, 'h3000_0000,
    'h4000_0000, 'h5000_0000, 'h6000_0000, 'h7000_0000
  },
  parameter logic [APB_ADDR_WIDTH-1:0] ADDR_SIZE [APB_SLAVE_COUNT] = '{default: 'h1000},
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  apb_demux_wd_if.slave       bus,
  output logic                decerr_o,
  output logic                timeout_o,
  output logic [7:0]          err_count_o
);

  localparam int unsigned IDX_W = (APB_SLAVE_COUNT > 1) ? $clog2(APB_SLAVE_COUNT) : 1;
  localparam int unsigned WD_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W  = (WD_RAW_W > 0) ? WD_RAW_W : 1;
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP_S  = 2'd1;
  localparam logic [1:0] ACCESS_S = 2'd2;
  localparam logic [1:0] ERR      = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [7:0]                err_cnt_q, err_cnt_d;

  // ---------------------------------------------------------------------------
  // Address decode on the live master address; used only when a SETUP is seen
  // ---------------------------------------------------------------------------
  logic             hit_any;
  logic             hit_multi;
  logic [IDX_W-1:0] hit_idx;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < APB_SLAVE_COUNT; i++) begin
      // Offset compare at address width: no wrap at the top of the address map,
      // and a zero-sized window can never hit.
      if ((bus.paddr_i >= BASE_ADDR[i]) &&
          ((bus.paddr_i - BASE_ADDR[i]) < ADDR_SIZE[i])) begin
        hit_multi = hit_multi | hit_any;
        hit_any   = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selected-slave response mux and watchdog condition
  // ---------------------------------------------------------------------------
  logic [APB_SLAVE_COUNT-1:0] sel_onehot;
  logic                       pready_sel;
  logic                       pslverr_sel;
  logic [APB_DATA_WIDTH-1:0]  prdata_sel;
  logic                       wd_fire;

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[idx_q] = 1'b1;
  end

  assign pready_sel  = bus.pready_i[idx_q];
  assign pslverr_sel = bus.pslverr_i[idx_q];
  assign prdata_sel  = bus.prdata_i[idx_q];

  // Fires in the TIMEOUT_CYCLES-th consecutive low-ready ACCESS cycle; a slave
  // that becomes ready in that same cycle completes normally instead.
  assign wd_fire = WD_EN && (state_q == ACCESS_S) && bus.psel_i &&
                   !pready_sel && (wd_q == WD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    wd_d    = wd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.psel_i && !bus.penable_i) begin
          idx_d   = hit_idx;
          addr_d  = bus.paddr_i;
          wdata_d = bus.pwdata_i;
          write_d = bus.pwrite_i;
          state_d = (hit_any && !hit_multi) ? SETUP_S : ERR;
        end
      end
      SETUP_S: begin
        wd_d    = '0;
        state_d = bus.psel_i ? ACCESS_S : IDLE;
      end
      ACCESS_S: begin
        // A dropped psel_i abandons the transfer quietly; it is not an error.
        if (!bus.psel_i || pready_sel || wd_fire) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Master response and slave control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pready_o  = 1'b0;
    bus.pslverr_o = 1'b0;
    bus.prdata_o  = '0;
    bus.psel_o    = '0;
    bus.penable_o = '0;
    decerr_o      = 1'b0;
    timeout_o     = 1'b0;

    unique case (state_q)
      SETUP_S: begin
        bus.psel_o = sel_onehot;
      end
      ACCESS_S: begin
        bus.psel_o    = sel_onehot;
        bus.penable_o = sel_onehot;
        if (wd_fire) begin
          bus.pready_o  = 1'b1;
          bus.pslverr_o = 1'b1;
          timeout_o     = 1'b1;
        end else begin
          bus.pready_o  = pready_sel;
          bus.pslverr_o = pslverr_sel;
          bus.prdata_o  = prdata_sel;
        end
      end
      ERR: begin
        bus.pready_o  = 1'b1;
        bus.pslverr_o = 1'b1;
        decerr_o      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Address, data and direction are broadcast; only psel/penable single out a slave.
  always_comb begin
    for (int i = 0; i < APB_SLAVE_COUNT; i++) begin
      bus.paddr_o[i]  = addr_q;
      bus.pwdata_o[i] = wdata_q;
      bus.pwrite_o[i] = write_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter, saturating at 255
  // ---------------------------------------------------------------------------
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((decerr_o || timeout_o) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign err_count_o = err_cnt_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      wd_q      <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      wd_q      <= wd_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_demux_wd.sv
// Directed bench for apb_demux_wd: decode, decode error, window boundary,
// watchdog timeout and its last-cycle race, and asynchronous reset mid-access.
module tb_apb_demux_wd;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic       clk_i;
  logic       rst_ni;
  logic       decerr_o;
  logic       timeout_o;
  logic [7:0] err_count_o;

  int checks   = 0;
  int failures = 0;

  apb_demux_wd_if #(.APB_SLAVE_COUNT(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_demux_wd #(
    .APB_SLAVE_COUNT(N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .decerr_o    (decerr_o),
    .timeout_o   (timeout_o),
    .err_count_o (err_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Move to the falling edge of the current cycle, where outputs are sampled.
  task automatic sample_point();
    @(negedge clk_i);
  endtask

  task automatic drive_setup(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] data);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = addr;
    bus.pwrite_i  = wr;
    bus.pwdata_i  = data;
  endtask

  task automatic drive_idle();
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = '0;
    bus.pwdata_i  = '0;
    bus.pready_i  = '1;
    bus.pslverr_i = '0;
    for (int i = 0; i < N; i++) bus.prdata_i[i] = 32'hCAFE_0000 | 32'(i);

    // Reset state
    repeat (2) next_cycle();
    sample_point();
    check("rst_psel",    64'(bus.psel_o),    64'h0);
    check("rst_pready",  64'(bus.pready_o),  64'h0);
    check("rst_paddr0",  64'(bus.paddr_o[0]), 64'h0);
    check("rst_errcnt",  64'(err_count_o),   64'h0);
    next_cycle();
    rst_ni = 1'b1;

    // Read slave 2: T setup, T+1 slave setup, T+2 completion
    next_cycle();
    drive_setup(32'h2000_0010, 1'b0, 32'h0);
    sample_point();
    check("rd2_T_psel",    64'(bus.psel_o),   64'h0);
    check("rd2_T_pready",  64'(bus.pready_o), 64'h0);
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("rd2_T1_psel",    64'(bus.psel_o),     64'h04);
    check("rd2_T1_penable", 64'(bus.penable_o),  64'h00);
    check("rd2_T1_pready",  64'(bus.pready_o),   64'h0);
    check("rd2_T1_paddr2",  64'(bus.paddr_o[2]), 64'h2000_0010);
    next_cycle();
    sample_point();
    check("rd2_T2_psel",    64'(bus.psel_o),    64'h04);
    check("rd2_T2_penable", 64'(bus.penable_o), 64'h04);
    check("rd2_T2_pready",  64'(bus.pready_o),  64'h1);
    check("rd2_T2_prdata",  64'(bus.prdata_o),  64'hCAFE_0002);
    check("rd2_T2_pslverr", 64'(bus.pslverr_o), 64'h0);

    // Back-to-back write at the top of slave 3's window
    next_cycle();
    drive_setup(32'h3000_0FFF, 1'b1, 32'h1234_5678);
    sample_point();
    check("b2b_T_psel", 64'(bus.psel_o), 64'h0);
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("wr3_T1_psel",   64'(bus.psel_o),      64'h08);
    check("wr3_T1_pwrite", 64'(bus.pwrite_o),    64'hFF);
    check("wr3_T1_pwdata", 64'(bus.pwdata_o[3]), 64'h1234_5678);
    next_cycle();
    sample_point();
    check("wr3_T2_pready", 64'(bus.pready_o), 64'h1);
    check("wr3_T2_decerr", 64'(decerr_o),     64'h0);

    // Write to an unmapped address: decode error in T+1
    next_cycle();
    drive_setup(32'h8000_0000, 1'b1, 32'hDEAD_BEEF);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("unm_T1_pready",  64'(bus.pready_o),  64'h1);
    check("unm_T1_pslverr", 64'(bus.pslverr_o), 64'h1);
    check("unm_T1_decerr",  64'(decerr_o),      64'h1);
    check("unm_T1_psel",    64'(bus.psel_o),    64'h0);
    check("unm_T1_prdata",  64'(bus.prdata_o),  64'h0);
    next_cycle();
    drive_idle();
    sample_point();
    check("unm_T2_errcnt", 64'(err_count_o), 64'h1);
    check("unm_T2_decerr", 64'(decerr_o),    64'h0);

    // One past the end of slave 3's window
    next_cycle();
    drive_setup(32'h3000_1000, 1'b0, 32'h0);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("bnd_T1_decerr", 64'(decerr_o),     64'h1);
    check("bnd_T1_psel",   64'(bus.psel_o),   64'h0);
    next_cycle();
    drive_idle();
    sample_point();
    check("bnd_T2_errcnt", 64'(err_count_o), 64'h2);

    // Slave 5 never ready: watchdog completes at T+17
    bus.pready_i[5] = 1'b0;
    next_cycle();
    drive_setup(32'h5000_0040, 1'b0, 32'h0);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("to_T1_psel", 64'(bus.psel_o), 64'h20);
    for (int k = 2; k <= 16; k++) begin
      next_cycle();
      sample_point();
      check($sformatf("to_T%0d_pready", k), 64'(bus.pready_o), 64'h0);
    end
    next_cycle();
    sample_point();
    check("to_T17_timeout", 64'(timeout_o),     64'h1);
    check("to_T17_pready",  64'(bus.pready_o),  64'h1);
    check("to_T17_pslverr", 64'(bus.pslverr_o), 64'h1);
    check("to_T17_prdata",  64'(bus.prdata_o),  64'h0);
    next_cycle();
    drive_idle();
    sample_point();
    check("to_T18_psel",    64'(bus.psel_o),  64'h0);
    check("to_T18_timeout", 64'(timeout_o),   64'h0);
    check("to_T18_errcnt",  64'(err_count_o), 64'h3);

    // Slave 5 ready in exactly the 16th ACCESS cycle: normal completion wins
    next_cycle();
    drive_setup(32'h5000_0080, 1'b0, 32'h0);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    for (int k = 2; k <= 16; k++) begin
      next_cycle();
      sample_point();
    end
    check("race_T16_pready", 64'(bus.pready_o), 64'h0);
    next_cycle();
    bus.pready_i[5] = 1'b1;
    sample_point();
    check("race_T17_timeout", 64'(timeout_o),     64'h0);
    check("race_T17_pready",  64'(bus.pready_o),  64'h1);
    check("race_T17_pslverr", 64'(bus.pslverr_o), 64'h0);
    check("race_T17_prdata",  64'(bus.prdata_o),  64'hCAFE_0005);
    next_cycle();
    drive_idle();
    sample_point();
    check("race_T18_errcnt", 64'(err_count_o), 64'h3);

    // Asynchronous reset while slave 1 is held in ACCESS
    bus.pready_i[1] = 1'b0;
    next_cycle();
    drive_setup(32'h1000_0004, 1'b0, 32'h0);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    next_cycle();
    sample_point();
    check("ar_pre_psel", 64'(bus.psel_o), 64'h02);
    #1;
    rst_ni = 1'b0;
    #1;
    check("ar_psel",    64'(bus.psel_o),     64'h0);
    check("ar_penable", 64'(bus.penable_o),  64'h0);
    check("ar_pready",  64'(bus.pready_o),   64'h0);
    check("ar_paddr1",  64'(bus.paddr_o[1]), 64'h0);
    check("ar_errcnt",  64'(err_count_o),    64'h0);
    drive_idle();
    next_cycle();
    rst_ni = 1'b1;

    // Fresh read to slave 0 after reset
    next_cycle();
    drive_setup(32'h0000_0100, 1'b0, 32'h0);
    sample_point();
    next_cycle();
    bus.penable_i = 1'b1;
    sample_point();
    check("rd0_T1_psel", 64'(bus.psel_o), 64'h01);
    next_cycle();
    sample_point();
    check("rd0_T2_pready", 64'(bus.pready_o), 64'h1);
    check("rd0_T2_prdata", 64'(bus.prdata_o), 64'hCAFE_0000);
    next_cycle();
    drive_idle();
    sample_point();
    check("rd0_T3_psel", 64'(bus.psel_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
